// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the burst master: access-size encodings, the
// size-to-beat-count helper, the controller state enum and the memory window
// base address.
package mem_pkg;

  typedef enum logic [1:0] {
    ACC_1  = 2'b00,
    ACC_4  = 2'b01,
    ACC_8  = 2'b10,
    ACC_16 = 2'b11
  } acc_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WRITE,
    S_RWAIT,
    S_READ
  } state_e;

  localparam logic [31:0] MEM_BASE_ADDR = 32'h8002_0000;

  // Number of beats in a burst for a given access-size code.
  function automatic logic [4:0] beats(input logic [1:0] size);
    case (size)
      ACC_1:   beats = 5'd1;
      ACC_4:   beats = 5'd4;
      ACC_8:   beats = 5'd8;
      default: beats = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_wbuf.sv
// mem_wbuf
// Synchronous first-word-fall-through FIFO holding write beats until the
// memory burst is issued.
//   clk_i      clock
//   rst_i      synchronous active-high reset (empties the FIFO)
//   flush_i    synchronous flush (empties the FIFO)
//   push_i     write wr_data_i into the tail
//   wr_data_i  write data
//   pop_i      discard the head entry
//   rd_data_o  head entry (valid whenever count_o != 0)
//   count_o    number of stored words
module mem_wbuf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   wr_data_i,
  input  logic          pop_i,
  output logic [31:0]   rd_data_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master
// Accepts single/burst read and write requests from a client, buffers write
// beats, and drives a simple burst memory port. All outputs are registered.
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject misaligned requests with
// an err pulse instead of silently aligning the address).
//
// state  | meaning
// IDLE   | ready for a request
// FILL   | collecting write beats into the buffer
// ISSUE  | waiting for mem_busy_i low, then launching the command
// WRITE  | streaming buffered beats to memory, one per cycle
// RWAIT  | counting down the read latency before beat 0
// READ   | capturing read beats 1..N-1
//
// Ports:
//   clock_i, reset_i                         clock, sync active-high reset
//   req_valid_i/req_ready_o                  request handshake
//   req_addr_i, req_write_i, req_size_i      request attributes
//   wdata_valid_i/wdata_ready_o, wdata_i     write-beat stream
//   rdata_valid_o, rdata_o                   read-beat stream
//   done_o, err_o                            completion / rejection pulses
//   mem_enable_o, mem_wren_o, mem_acc_size_o,
//   mem_addr_o, mem_data_in_o                memory command + write data
//   mem_data_out_i, mem_busy_i               memory read data + not-ready
module mem_burst_master #(
  parameter int READ_LATENCY = 2,
  parameter int WBUF_DEPTH   = 16   // must be >= 16 to hold a full burst
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  input  logic [31:0] wdata_i,
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_enable_o,
  output logic        mem_wren_o,
  output logic [1:0]  mem_acc_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_in_o,
  input  logic [31:0] mem_data_out_i,
  input  logic        mem_busy_i
);

  import mem_pkg::*;

  localparam int WB_CW = $clog2(WBUF_DEPTH + 1);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [4:0]  beats_q;
  logic        write_q;
  logic [4:0]  cnt_q;
  logic [7:0]  wait_q;

  logic        req_ready_q;
  logic        wdata_ready_q;
  logic        rdata_valid_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        mem_enable_q;
  logic        mem_wren_q;
  logic [1:0]  mem_acc_size_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_in_q;

  logic             wb_push;
  logic             wb_pop;
  logic             wb_flush;
  logic [31:0]      wb_rd_data;
  logic [WB_CW-1:0] wb_count;
  logic             fill_last;
  logic             misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = |req_addr_i[1:0];
  assign err_o      = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign misaligned      = 1'b0;
  assign err_o           = 1'b0;
`endif

  assign wb_push   = (state_q == S_FILL) && wdata_ready_q && wdata_valid_i;
  // Compare against the count before this push lands.
  assign fill_last = (32'(wb_count) + 32'd1) == 32'(beats_q);
  // The head is consumed when beat 0 launches and for each later beat.
  assign wb_pop    = ((state_q == S_ISSUE) && write_q && !mem_busy_i) ||
                     ((state_q == S_WRITE) && (cnt_q != beats_q));
  assign wb_flush  = (state_q == S_WRITE) && (cnt_q == beats_q);

  mem_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .flush_i   (wb_flush),
    .push_i    (wb_push),
    .wr_data_i (wdata_i),
    .pop_i     (wb_pop),
    .rd_data_o (wb_rd_data),
    .count_o   (wb_count)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      size_q         <= '0;
      beats_q        <= '0;
      write_q        <= 1'b0;
      cnt_q          <= '0;
      wait_q         <= '0;
      req_ready_q    <= 1'b1;
      wdata_ready_q  <= 1'b0;
      rdata_valid_q  <= 1'b0;
      rdata_q        <= '0;
      done_q         <= 1'b0;
      mem_enable_q   <= 1'b0;
      mem_wren_q     <= 1'b0;
      mem_acc_size_q <= '0;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q          <= 1'b0;
`endif
    end else begin
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
              err_q <= 1'b1;
`endif
            end else begin
              addr_q      <= {req_addr_i[31:2], 2'b00};
              size_q      <= req_size_i;
              beats_q     <= beats(req_size_i);
              write_q     <= req_write_i;
              req_ready_q <= 1'b0;
              if (req_write_i) begin
                wdata_ready_q <= 1'b1;
                state_q       <= S_FILL;
              end else begin
                state_q <= S_ISSUE;
              end
            end
          end
        end

        S_FILL: begin
          if (wb_push && fill_last) begin
            wdata_ready_q <= 1'b0;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!mem_busy_i) begin
            mem_enable_q   <= 1'b1;
            mem_addr_q     <= addr_q;
            mem_acc_size_q <= size_q;
            mem_wren_q     <= write_q;
            cnt_q          <= 5'd1;
            if (write_q) begin
              mem_data_in_q <= wb_rd_data;
              state_q       <= S_WRITE;
            end else begin
              wait_q  <= 8'(READ_LATENCY);
              state_q <= S_RWAIT;
            end
          end
        end

        S_WRITE: begin
          // cnt_q counts beats already on the bus.
          if (cnt_q == beats_q) begin
            mem_enable_q <= 1'b0;
            mem_wren_q   <= 1'b0;
            done_q       <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            mem_data_in_q <= wb_rd_data;
            cnt_q         <= cnt_q + 5'd1;
          end
        end

        S_RWAIT: begin
          if (wait_q == 8'd0) begin
            rdata_q       <= mem_data_out_i;
            rdata_valid_q <= 1'b1;
            cnt_q         <= 5'd1;
            if (beats_q == 5'd1) begin
              mem_enable_q <= 1'b0;
              done_q       <= 1'b1;
              req_ready_q  <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              state_q <= S_READ;
            end
          end else begin
            wait_q <= wait_q - 8'd1;
          end
        end

        S_READ: begin
          rdata_q       <= mem_data_out_i;
          rdata_valid_q <= 1'b1;
          cnt_q         <= cnt_q + 5'd1;
          if (cnt_q == beats_q - 5'd1) begin
            mem_enable_q <= 1'b0;
            done_q       <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign wdata_ready_o  = wdata_ready_q;
  assign rdata_valid_o  = rdata_valid_q;
  assign rdata_o        = rdata_q;
  assign done_o         = done_q;
  assign mem_enable_o   = mem_enable_q;
  assign mem_wren_o     = mem_wren_q;
  assign mem_acc_size_o = mem_acc_size_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_in_o  = mem_data_in_q;

endmodule

// File: tb/tb_mem_burst_master.sv
`timescale 1ns/1ps
module tb_mem_burst_master;
  import mem_pkg::*;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        wdata_valid;
  logic        wdata_ready_o;
  logic [31:0] wdata;
  logic        rdata_valid_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        mem_enable_o;
  logic        mem_wren_o;
  logic [1:0]  mem_acc_size_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_in_o;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] rmem   [4];
  logic [31:0] wbeats [16];

  always #5 clk = ~clk;

  mem_burst_master #(
    .READ_LATENCY(RL),
    .WBUF_DEPTH  (16)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .wdata_valid_i  (wdata_valid),
    .wdata_ready_o  (wdata_ready_o),
    .wdata_i        (wdata),
    .rdata_valid_o  (rdata_valid_o),
    .rdata_o        (rdata_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .mem_enable_o   (mem_enable_o),
    .mem_wren_o     (mem_wren_o),
    .mem_acc_size_o (mem_acc_size_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_in_o  (mem_data_in_o),
    .mem_data_out_i (mem_data_out),
    .mem_busy_i     (mem_busy)
  );

  // Memory read model: beat k is on mem_data_out during the cycle that is
  // RL+k cycles after the first cycle of mem_enable.
  int   since_cmd = 1000;
  logic prev_en   = 1'b0;
  always @(negedge clk) begin
    if (mem_enable_o && !prev_en) since_cmd = 0;
    else if (since_cmd < 1000) since_cmd = since_cmd + 1;
    prev_en = mem_enable_o;
    if (since_cmd >= RL && since_cmd < RL + 4) mem_data_out = rmem[since_cmd - RL];
    else mem_data_out = 32'hDEAD_BEEF;
  end

  task automatic send_req(input logic [31:0] a, input logic w, input logic [1:0] s);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_size = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic feed_wdata(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 60) begin
      if (wdata_ready_o) begin
        wdata_valid = 1'b1; wdata = wbeats[i]; i++;
      end else begin
        wdata_valid = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_enable(output int g);
    g = 0;
    while (!mem_enable_o && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready_o); end
    total++; if (wdata_ready_o !== 1'b0) begin bad++; $display("FAIL rst_wdata_ready got=%b want=0", wdata_ready_o); end
    total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rdata_valid got=%b want=0", rdata_valid_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_o); end
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_mem_enable got=%b want=0", mem_enable_o); end
    total++; if (mem_wren_o !== 1'b0) begin bad++; $display("FAIL rst_mem_wren got=%b want=0", mem_wren_o); end
    total++; if (mem_acc_size_o !== 2'b00) begin bad++; $display("FAIL rst_acc_size got=%b want=00", mem_acc_size_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr_o); end
    total++; if (mem_data_in_o !== 32'h0) begin bad++; $display("FAIL rst_mem_data_in got=%h want=0", mem_data_in_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int g;
    wbeats[0] = 32'h55cc_55cc;
    send_req(MEM_BASE_ADDR, 1'b1, 2'b00);
    total++; if (wdata_ready_o !== 1'b1) begin bad++; $display("FAIL sw_wdata_ready got=%b want=1", wdata_ready_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL sw_req_ready_busy got=%b want=0", req_ready_o); end
    feed_wdata(1);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL sw_issue_latency got=%0d want=1", g); end
    total++; if (mem_wren_o !== 1'b1) begin bad++; $display("FAIL sw_wren got=%b want=1", mem_wren_o); end
    total++; if (mem_data_in_o !== 32'h55cc_55cc) begin bad++; $display("FAIL sw_data got=%h want=55cc55cc", mem_data_in_o); end
    total++; if (mem_addr_o !== 32'h8002_0000) begin bad++; $display("FAIL sw_addr got=%h want=80020000", mem_addr_o); end
    total++; if (mem_acc_size_o !== 2'b00) begin bad++; $display("FAIL sw_acc got=%b want=00", mem_acc_size_o); end
    @(negedge clk);
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL sw_enable_end got=%b want=0", mem_enable_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL sw_done got=%b want=1", done_o); end
    @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL sw_done_pulse got=%b want=0", done_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL sw_req_ready_idle got=%b want=1", req_ready_o); end
  endtask

  task automatic test_burst_write();
    int g;
    wbeats[0] = 32'h55cc_55cd; wbeats[1] = 32'h55cc_55ce;
    wbeats[2] = 32'h55cc_55cf; wbeats[3] = 32'h55cc_55c1;
    send_req(32'h8002_0004, 1'b1, 2'b01);
    feed_wdata(4);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL bw_issue_latency got=%0d want=1", g); end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_enable_o !== 1'b1) begin bad++; $display("FAIL bw_enable beat=%0d got=%b want=1", k, mem_enable_o); end
      total++; if (mem_data_in_o !== wbeats[k]) begin bad++; $display("FAIL bw_data beat=%0d got=%h want=%h", k, mem_data_in_o, wbeats[k]); end
      total++; if (mem_acc_size_o !== 2'b01) begin bad++; $display("FAIL bw_acc beat=%0d got=%b want=01", k, mem_acc_size_o); end
      total++; if (mem_addr_o !== 32'h8002_0004) begin bad++; $display("FAIL bw_addr beat=%0d got=%h want=80020004", k, mem_addr_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL bw_early_done beat=%0d got=%b want=0", k, done_o); end
      @(negedge clk);
    end
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL bw_enable_end got=%b want=0", mem_enable_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL bw_done got=%b want=1", done_o); end
  endtask

  task automatic test_burst_read();
    int g;
    send_req(32'h8002_0000, 1'b0, 2'b01);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL br_issue_latency got=%0d want=1", g); end
    total++; if (mem_wren_o !== 1'b0) begin bad++; $display("FAIL br_wren got=%b want=0", mem_wren_o); end
    total++; if (mem_acc_size_o !== 2'b01) begin bad++; $display("FAIL br_acc got=%b want=01", mem_acc_size_o); end
    for (int j = 1; j <= RL; j++) begin
      @(negedge clk);
      total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL br_early_valid cyc=%0d got=%b want=0", j, rdata_valid_o); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (rdata_valid_o !== 1'b1) begin bad++; $display("FAIL br_valid beat=%0d got=%b want=1", k, rdata_valid_o); end
      total++; if (rdata_o !== rmem[k]) begin bad++; $display("FAIL br_data beat=%0d got=%h want=%h", k, rdata_o, rmem[k]); end
      total++; if (done_o !== (k == 3)) begin bad++; $display("FAIL br_done beat=%0d got=%b want=%b", k, done_o, (k == 3)); end
      total++; if (mem_enable_o !== (k != 3)) begin bad++; $display("FAIL br_enable beat=%0d got=%b want=%b", k, mem_enable_o, (k != 3)); end
    end
    @(negedge clk);
    total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL br_valid_after got=%b want=0", rdata_valid_o); end
  endtask

  task automatic test_busy();
    int g;
    for (int i = 0; i < 4; i++) wbeats[i] = 32'h1111_0001 + i;
    mem_busy = 1'b1;
    send_req(32'h8002_0040, 1'b1, 2'b01);
    feed_wdata(4);
    for (int j = 0; j < 5; j++) begin
      total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL busy_enable cyc=%0d got=%b want=0", j, mem_enable_o); end
      @(negedge clk);
    end
    mem_busy = 1'b0;
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL busy_start got=%0d want=1", g); end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_data_in_o !== wbeats[k]) begin bad++; $display("FAIL busy_data beat=%0d got=%h want=%h", k, mem_data_in_o, wbeats[k]); end
      total++; if (mem_enable_o !== 1'b1) begin bad++; $display("FAIL busy_enable_mid beat=%0d got=%b want=1", k, mem_enable_o); end
      if (k == 1) mem_busy = 1'b1;
      if (k == 3) mem_busy = 1'b0;
      @(negedge clk);
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL busy_done got=%b want=1", done_o); end
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL busy_enable_end got=%b want=0", mem_enable_o); end
  endtask

  task automatic test_reset_mid();
    int g;
    for (int i = 0; i < 16; i++) wbeats[i] = 32'hA000_0000 + i;
    send_req(32'h8002_0100, 1'b1, 2'b11);
    feed_wdata(16);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL rm_issue_latency got=%0d want=1", g); end
    for (int k = 0; k < 3; k++) begin
      total++; if (mem_data_in_o !== wbeats[k]) begin bad++; $display("FAIL rm_data beat=%0d got=%h want=%h", k, mem_data_in_o, wbeats[k]); end
      if (k == 2) rst = 1'b1;
      @(negedge clk);
    end
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL rm_enable got=%b want=0", mem_enable_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rm_done got=%b want=0", done_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rm_req_ready got=%b want=1", req_ready_o); end
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++; if (done_o !== 1'b0 || mem_enable_o !== 1'b0) begin bad++; $display("FAIL rm_quiet cyc=%0d done=%b en=%b want=0/0", j, done_o, mem_enable_o); end
    end
    wbeats[0] = 32'h0123_4567;
    send_req(32'h8002_0008, 1'b1, 2'b00);
    feed_wdata(1);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL rm_next_latency got=%0d want=1", g); end
    total++; if (mem_data_in_o !== 32'h0123_4567) begin bad++; $display("FAIL rm_next_data got=%h want=01234567", mem_data_in_o); end
    total++; if (mem_addr_o !== 32'h8002_0008) begin bad++; $display("FAIL rm_next_addr got=%h want=80020008", mem_addr_o); end
    @(negedge clk);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL rm_next_done got=%b want=1", done_o); end
  endtask

  task automatic test_back_to_back();
    int g;
    wdata_valid = 1'b1; wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8002_0000; req_write = 1'b0; req_size = 2'b00;
    @(negedge clk);
    req_addr = 32'h8002_0010;
    for (int j = 0; j < 4; j++) begin
      total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_req_ready cyc=%0d got=%b want=0", j, req_ready_o); end
      total++; if (wdata_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_wdata_ready cyc=%0d got=%b want=0", j, wdata_ready_o); end
      @(negedge clk);
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", done_o); end
    total++; if (rdata_o !== rmem[0]) begin bad++; $display("FAIL b2b_data1 got=%h want=%h", rdata_o, rmem[0]); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b want=1", req_ready_o); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_accept2 got=%b want=0", req_ready_o); end
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL b2b_issue2 got=%0d want=1", g); end
    total++; if (mem_addr_o !== 32'h8002_0010) begin bad++; $display("FAIL b2b_addr2 got=%h want=80020010", mem_addr_o); end
    repeat (RL + 1) @(negedge clk);
    total++; if (rdata_valid_o !== 1'b1 || rdata_o !== rmem[0]) begin bad++; $display("FAIL b2b_data2 got=%b/%h want=1/%h", rdata_valid_o, rdata_o, rmem[0]); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b want=1", done_o); end
    wdata_valid = 1'b0;
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    send_req(32'h8002_0002, 1'b1, 2'b00);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL al_err got=%b want=1", err_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL al_req_ready got=%b want=1", req_ready_o); end
    total++; if (wdata_ready_o !== 1'b0) begin bad++; $display("FAIL al_wdata_ready got=%b want=0", wdata_ready_o); end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      total++; if (mem_enable_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL al_quiet cyc=%0d en=%b err=%b want=0/0", j, mem_enable_o, err_o); end
    end
`else
    int g;
    send_req(32'h8002_0003, 1'b0, 2'b00);
    wait_enable(g);
    total++; if (g !== 1) begin bad++; $display("FAIL al_issue got=%0d want=1", g); end
    total++; if (mem_addr_o !== MEM_BASE_ADDR) begin bad++; $display("FAIL al_addr_forced got=%h want=%h", mem_addr_o, MEM_BASE_ADDR); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL al_err_tied got=%b want=0", err_o); end
    repeat (RL + 1) @(negedge clk);
    total++; if (rdata_o !== rmem[0] || done_o !== 1'b1) begin bad++; $display("FAIL al_read got=%h/%b want=%h/1", rdata_o, done_o, rmem[0]); end
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = 2'b00;
    wdata_valid = 1'b0; wdata = '0; mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) rmem[i] = 32'h55cc_55cc + i;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_align();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameter READ_LATENCY, default 2, cycles from request issue to read beat 0 on mem_data_out.
REQ-002 Parameter WBUF_DEPTH, default 16, write-beat buffer depth in words; SHALL be at least 16.
REQ-003 clock  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  client request handshake; transfer when both high.
REQ-006 req_addr  in  32  byte address of burst beat 0.
REQ-007 req_write  in  1  1 = write burst, 0 = read burst.
REQ-008 req_size  in  2  00 = 1 beat, 01 = 4 beats, 10 = 8 beats, 11 = 16 beats.
REQ-009 wdata_valid / wdata_ready / wdata  in / out / in  1 / 1 / 32  client write-beat stream.
REQ-010 rdata_valid / rdata  out / out  1 / 32  read-beat stream; no backpressure.
REQ-011 done / err  out / out  1 / 1  one-cycle pulses: burst complete / request rejected.
REQ-012 mem_enable, mem_wren, mem_acc_size[2], mem_addr[32], mem_data_in[32]  out  memory command and write data.
REQ-013 mem_data_out[32], mem_busy[1]  in  memory read data and not-ready flag.

Function
REQ-014 States: IDLE, FILL, ISSUE, WRITE, RWAIT, READ.
REQ-015 IDLE: req_ready=1; on handshake, latch addr/size/write; write goes to FILL, read goes to ISSUE.
REQ-016 FILL: wdata_ready=1 until beats(size) words are buffered, then ISSUE; req_ready=0 outside IDLE.
REQ-017 ISSUE: wait while mem_busy=1; when mem_busy=0, drive mem_enable=1, mem_addr, mem_acc_size, mem_wren=write, and for writes mem_data_in=beat 0.
REQ-018 WRITE: mem_enable held high; one buffered beat per cycle on mem_data_in, with no gaps; after the last beat, mem_enable=0, done pulses, return to IDLE.
REQ-019 RWAIT/READ: mem_enable held high; beat k of mem_data_out is sampled READ_LATENCY+k cycles after the ISSUE cycle and presented on rdata with rdata_valid=1 one cycle later.
REQ-020 Read completion: after the last beat, mem_enable=0, done pulses together with the last rdata_valid, return to IDLE.
REQ-021 mem_busy is sampled only in ISSUE; it is ignored mid-burst.
REQ-022 mem_addr is held at the beat-0 address for the whole burst; the memory increments internally by 4 per beat.
REQ-023 The beat counter is 5 bits; beats(size) = 1, 4, 8, 16; the counter never wraps within a burst.
REQ-024 Simultaneous req_valid during a busy burst: ignored (req_ready=0); the request is accepted the cycle after return to IDLE.
REQ-025 wdata_valid outside FILL is not consumed (wdata_ready=0).

Reset
REQ-026 Reset values: req_ready=1, wdata_ready=0, rdata_valid=0, rdata=0, done=0, err=0, mem_enable=0, mem_wren=0, mem_acc_size=00, mem_addr=0, mem_data_in=0; state IDLE.
REQ-027 Reset mid-burst: abandon the burst, flush the buffer, mem_enable=0 in the next cycle; no done pulse.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: a request with req_addr[1:0]!=00 is accepted, err pulses one cycle later, no memory access occurs, and the block stays in IDLE.
REQ-029 Macro MEM_ALIGN_CHECK_EN undefined: err is tied to 0 and req_addr[1:0] is forced to 00 on mem_addr.

Structure
REQ-030 Package mem_pkg: acc_size encodings, beats() function, state enum, constant MEM_BASE_ADDR = 32'h8002_0000.
REQ-031 Sub-module mem_wbuf: synchronous FIFO of WBUF_DEPTH x 32 with push, pop, count and flush; flushed on reset and on burst completion.

Verification
REQ-032 Single write addr 8002_0000, size 00, data 55cc_55cc -> one cycle of mem_enable=1, mem_wren=1, mem_data_in=55cc_55cc, then done.
REQ-033 Burst write addr 8002_0004, size 01, data 55cc_55cd/ce/cf/c1 -> four consecutive mem_data_in beats in order, mem_acc_size=01, done after beat 4.
REQ-034 Burst read addr 8002_0000, size 01, with a memory model preloaded 55cc_55cc..55cc_55cf -> rdata_valid on 4 consecutive cycles starting READ_LATENCY+1 cycles after ISSUE, values in order, done with the last beat.
REQ-035 mem_busy=1 for 5 cycles at ISSUE -> mem_enable stays 0 through those cycles, the burst starts on the first cycle mem_busy=0, and data is intact.
REQ-036 reset asserted on the 3rd beat of a 16-beat write -> mem_enable=0 the next cycle, no done, and the next request starts cleanly.
REQ-037 With MEM_ALIGN_CHECK_EN defined, req_addr 8002_0002 -> err pulse, mem_enable never asserted.
